// File: rtl/iob_cache_be_pkg.sv
// Shared types for the cache back-end AXI arbiter.
// FSM state encodings and AXI burst/response codes.
package iob_cache_be_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/iob_cache_rr_arb.sv
// Round-robin arbiter: search starts at ptr_q,
// ptr_q moves past the grant on upd_i.
module iob_cache_rr_arb
  import iob_cache_be_pkg::*;
#(
  parameter int NPORTS = 2
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [NPORTS-1:0] req_i,
  input  logic              upd_i,
  output logic [NPORTS-1:0] gnt_o
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;
  logic [PW-1:0]         sel;
  logic [2*NPORTS-1:0]   dreq;

  // Rotated request: bit j is port (ptr_q + j) mod NPORTS
  assign dreq = {req_i, req_i} >> ptr_q;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    sel   = '0;
    for (int j = NPORTS - 1; j >= 0; j--) begin
      if (dreq[j]) begin
        sel   = PW'((int'(ptr_q) + j) % NPORTS);
        gnt_o = NPORTS'(1) << sel;
        ptr_d = PW'((int'(ptr_q) + j + 1) % NPORTS);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ptr_q <= '0;
    end else if (upd_i && (|gnt_o)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/iob_cache_be_axi_arb.sv
// Cache back-end: arbitrates line refills and
// single-beat writes from NPORTS onto one AXI4 master.
module iob_cache_be_axi_arb
  import iob_cache_be_pkg::*;
#(
  parameter int         NPORTS       = 2,
  parameter int         ADDR_W       = 32,
  parameter int         DATA_W       = 32,
  parameter int         LINE_BEATS_W = 2,
  parameter int         AXI_ID_W     = 1,
  parameter int         AXI_ID       = 0,
  parameter int         AXI_LEN_W    = 8,
  parameter logic [3:0] CACHE_MODE   = 4'b0011,
  parameter bit         WRAP_EN      = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NPORTS-1:0]          rd_valid_i,
  input  logic [NPORTS*ADDR_W-1:0]   rd_addr_i,
  output logic [NPORTS-1:0]          rd_ready_o,
  output logic [NPORTS-1:0]          rd_rvalid_o,
  output logic [DATA_W-1:0]          rd_rdata_o,
  output logic                       rd_rlast_o,
  output logic                       rd_err_o,
  input  logic [NPORTS-1:0]          wr_valid_i,
  input  logic [NPORTS*ADDR_W-1:0]   wr_addr_i,
  input  logic [NPORTS*DATA_W-1:0]   wr_wdata_i,
  input  logic [NPORTS*DATA_W/8-1:0] wr_wstrb_i,
  output logic [NPORTS-1:0]          wr_ready_o,
  output logic                       wr_err_o,
  output logic [AXI_ID_W-1:0]        axi_awid_o,
  output logic [ADDR_W-1:0]          axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]       axi_awlen_o,
  output logic [2:0]                 axi_awsize_o,
  output logic [1:0]                 axi_awburst_o,
  output logic                       axi_awlock_o,
  output logic [3:0]                 axi_awcache_o,
  output logic [2:0]                 axi_awprot_o,
  output logic [3:0]                 axi_awqos_o,
  output logic [3:0]                 axi_awregion_o,
  output logic                       axi_awvalid_o,
  input  logic                       axi_awready_i,
  output logic [DATA_W-1:0]          axi_wdata_o,
  output logic [DATA_W/8-1:0]        axi_wstrb_o,
  output logic                       axi_wlast_o,
  output logic                       axi_wvalid_o,
  input  logic                       axi_wready_i,
  input  logic [AXI_ID_W-1:0]        axi_bid_i,
  input  logic [1:0]                 axi_bresp_i,
  input  logic                       axi_bvalid_i,
  output logic                       axi_bready_o,
  output logic [AXI_ID_W-1:0]        axi_arid_o,
  output logic [ADDR_W-1:0]          axi_araddr_o,
  output logic [AXI_LEN_W-1:0]       axi_arlen_o,
  output logic [2:0]                 axi_arsize_o,
  output logic [1:0]                 axi_arburst_o,
  output logic                       axi_arlock_o,
  output logic [3:0]                 axi_arcache_o,
  output logic [2:0]                 axi_arprot_o,
  output logic [3:0]                 axi_arqos_o,
  output logic [3:0]                 axi_arregion_o,
  output logic                       axi_arvalid_o,
  input  logic                       axi_arready_i,
  input  logic [AXI_ID_W-1:0]        axi_rid_i,
  input  logic [DATA_W-1:0]          axi_rdata_i,
  input  logic [1:0]                 axi_rresp_i,
  input  logic                       axi_rlast_i,
  input  logic                       axi_rvalid_i,
  output logic                       axi_rready_o
);

  localparam int PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int BYTE_W   = $clog2(DATA_W / 8);
  localparam int LINE_OFF = LINE_BEATS_W + BYTE_W;
  localparam int LTAG_W   = ADDR_W - LINE_OFF;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] BEAT_MASK =
    ~((ADDR_W'(1) << BYTE_W) - ADDR_W'(1));

  function automatic logic [PW-1:0] oh2idx(
    input logic [NPORTS-1:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) oh2idx = PW'(i);
    end
  endfunction

  rd_state_e         rstate_q;
  logic [PW-1:0]     rport_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              rerr_q;

  wr_state_e         wstate_q;
  logic [PW-1:0]     wport_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;

  logic [NPORTS-1:0] rport_oh;
  logic [NPORTS-1:0] wport_oh;
  logic [NPORTS-1:0] rreq;
  logic [NPORTS-1:0] wreq;
  logic [NPORTS-1:0] rgnt;
  logic [NPORTS-1:0] wgnt;
  logic [NPORTS-1:0] hazard;
  logic [ADDR_W-1:0] waddr;
  logic              wbusy;
  logic              rbeat;
  logic              rupd;
  logic              wupd;
  logic              aw_done;
  logic              w_done;
  logic              unused_ids;

  assign unused_ids = ^{axi_bid_i, axi_rid_i};

  assign rport_oh = NPORTS'(1) << rport_q;
  assign wport_oh = NPORTS'(1) << wport_q;
  assign waddr    =
    wr_addr_i[int'(wport_q)*ADDR_W +: ADDR_W];
  assign wbusy    = (wstate_q != W_IDLE);

  // Hold off refills of a line with a write in flight
  always_comb begin
    hazard = '0;
    for (int p = 0; p < NPORTS; p++) begin
      hazard[p] = wbusy &&
        (rd_addr_i[p*ADDR_W+LINE_OFF +: LTAG_W] ==
         waddr[ADDR_W-1:LINE_OFF]);
    end
  end

  assign rreq = (rstate_q == R_IDLE) ?
                (rd_valid_i & ~hazard) : rport_oh;
  assign wreq = (wstate_q == W_IDLE) ?
                wr_valid_i : wport_oh;

  assign rbeat = rready_q & axi_rvalid_i;
  assign rupd  = rbeat & axi_rlast_i;
  assign wupd  = bready_q & axi_bvalid_i;

  iob_cache_rr_arb #(
    .NPORTS (NPORTS)
  ) u_rd_arb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req_i    (rreq),
    .upd_i    (rupd),
    .gnt_o    (rgnt)
  );

  iob_cache_rr_arb #(
    .NPORTS (NPORTS)
  ) u_wr_arb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req_i    (wreq),
    .upd_i    (wupd),
    .gnt_o    (wgnt)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rstate_q  <= R_IDLE;
      rport_q   <= '0;
      raddr_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      unique case (rstate_q)
        R_IDLE: begin
          if (|rgnt) begin
            rport_q   <= oh2idx(rgnt);
            raddr_q   <=
              rd_addr_i[int'(oh2idx(rgnt))*ADDR_W +: ADDR_W];
            arvalid_q <= 1'b1;
            rstate_q  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rvalid_i) begin
            rerr_q <= rerr_q |
                      (axi_rresp_i != AXI_RESP_OKAY);
            if (axi_rlast_i) begin
              rerr_q   <= 1'b0;
              rready_q <= 1'b0;
              rstate_q <= R_IDLE;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign aw_done = ~awvalid_q | axi_awready_i;
  assign w_done  = ~wvalid_q | axi_wready_i;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wstate_q  <= W_IDLE;
      wport_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      unique case (wstate_q)
        W_IDLE: begin
          if (|wgnt) begin
            wport_q   <= oh2idx(wgnt);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wstate_q  <= W_REQ;
          end
        end
        W_REQ: begin
          if (axi_awready_i) awvalid_q <= 1'b0;
          if (axi_wready_i) wvalid_q <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_bvalid_i) begin
            bready_q <= 1'b0;
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign rd_ready_o  =
    (rstate_q == R_ADDR && axi_arready_i) ?
    rport_oh : '0;
  assign rd_rvalid_o = rbeat ? rport_oh : '0;
  assign rd_rdata_o  = axi_rdata_i;
  assign rd_rlast_o  = rupd;
  assign rd_err_o    = rupd &
    (rerr_q | (axi_rresp_i != AXI_RESP_OKAY));

  assign wr_ready_o = wupd ? wport_oh : '0;
  assign wr_err_o   = wupd &
    (axi_bresp_i != AXI_RESP_OKAY);

  assign axi_arid_o     = AXI_ID_W'(AXI_ID);
  assign axi_araddr_o   = WRAP_EN ?
    (raddr_q & BEAT_MASK) : (raddr_q & LINE_MASK);
  assign axi_arlen_o    =
    AXI_LEN_W'((1 << LINE_BEATS_W) - 1);
  assign axi_arsize_o   = 3'(BYTE_W);
  assign axi_arburst_o  = WRAP_EN ?
    AXI_BURST_WRAP : AXI_BURST_INCR;
  assign axi_arlock_o   = 1'b0;
  assign axi_arcache_o  = CACHE_MODE;
  assign axi_arprot_o   = 3'b000;
  assign axi_arqos_o    = 4'h0;
  assign axi_arregion_o = 4'h0;
  assign axi_arvalid_o  = arvalid_q;
  assign axi_rready_o   = rready_q;

  assign axi_awid_o     = AXI_ID_W'(AXI_ID);
  assign axi_awaddr_o   = waddr;
  assign axi_awlen_o    = '0;
  assign axi_awsize_o   = 3'(BYTE_W);
  assign axi_awburst_o  = AXI_BURST_INCR;
  assign axi_awlock_o   = 1'b0;
  assign axi_awcache_o  = CACHE_MODE;
  assign axi_awprot_o   = 3'b000;
  assign axi_awqos_o    = 4'h0;
  assign axi_awregion_o = 4'h0;
  assign axi_awvalid_o  = awvalid_q;
  assign axi_wdata_o    =
    wr_wdata_i[int'(wport_q)*DATA_W +: DATA_W];
  assign axi_wstrb_o    =
    wr_wstrb_i[int'(wport_q)*(DATA_W/8) +: DATA_W/8];
  assign axi_wlast_o    = 1'b1;
  assign axi_wvalid_o   = wvalid_q;
  assign axi_bready_o   = bready_q;

endmodule

// File: tb/tb_iob_cache_be_axi_arb.sv
// Bench for iob_cache_be_axi_arb: INCR (u0) and
// WRAP (u1) instances share stimulus.
module tb_iob_cache_be_axi_arb;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  logic [NP-1:0]    rd_valid;
  logic [NP*32-1:0] rd_addr;
  logic [NP-1:0]    wr_valid;
  logic [NP*32-1:0] wr_addr;
  logic [NP*32-1:0] wr_wdata;
  logic [NP*4-1:0]  wr_wstrb;
  logic awready, wready, bvalid, arready;
  logic rvalid, rlast, bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic [NP-1:0] rd_ready, rd_rvalid, wr_ready;
  logic [31:0] rd_rdata;
  logic rd_rlast, rd_err, wr_err;
  logic awid, awlock, awvalid, wlast, wvalid, bready;
  logic arid, arlock, arvalid, rready;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic [3:0]  awcache, arcache, awqos, arqos;
  logic [3:0]  awregion, arregion, wstrb;

  logic [NP-1:0] x_rd_ready, x_rd_rvalid, x_wr_ready;
  logic [31:0] x_rd_rdata;
  logic x_rd_rlast, x_rd_err, x_wr_err;
  logic x_awid, x_awlock, x_awvalid, x_wlast;
  logic x_wvalid, x_bready;
  logic x_arid, x_arlock, x_arvalid, x_rready;
  logic [31:0] x_awaddr, x_araddr, x_wdata;
  logic [7:0]  x_awlen, x_arlen;
  logic [2:0]  x_awsize, x_arsize, x_awprot, x_arprot;
  logic [1:0]  x_awburst, x_arburst;
  logic [3:0]  x_awcache, x_arcache, x_awqos, x_arqos;
  logic [3:0]  x_awregion, x_arregion, x_wstrb;

  int checks = 0;
  int failures = 0;
  int rd_ptr = 0;
  int wr_ptr = 0;

  always #5 clk = ~clk;

  iob_cache_be_axi_arb #(.WRAP_EN(1'b0)) u0 (
    .clk_i(clk), .arst_n_i(arst_n),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .rd_ready_o(rd_ready), .rd_rvalid_o(rd_rvalid),
    .rd_rdata_o(rd_rdata), .rd_rlast_o(rd_rlast),
    .rd_err_o(rd_err),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
    .wr_wdata_i(wr_wdata), .wr_wstrb_i(wr_wstrb),
    .wr_ready_o(wr_ready), .wr_err_o(wr_err),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr),
    .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awlock_o(awlock),
    .axi_awcache_o(awcache), .axi_awprot_o(awprot),
    .axi_awqos_o(awqos), .axi_awregion_o(awregion),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(wdata), .axi_wstrb_o(wstrb),
    .axi_wlast_o(wlast), .axi_wvalid_o(wvalid),
    .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp),
    .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr),
    .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arlock_o(arlock),
    .axi_arcache_o(arcache), .axi_arprot_o(arprot),
    .axi_arqos_o(arqos), .axi_arregion_o(arregion),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata),
    .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  iob_cache_be_axi_arb #(.WRAP_EN(1'b1)) u1 (
    .clk_i(clk), .arst_n_i(arst_n),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
    .rd_ready_o(x_rd_ready), .rd_rvalid_o(x_rd_rvalid),
    .rd_rdata_o(x_rd_rdata), .rd_rlast_o(x_rd_rlast),
    .rd_err_o(x_rd_err),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
    .wr_wdata_i(wr_wdata), .wr_wstrb_i(wr_wstrb),
    .wr_ready_o(x_wr_ready), .wr_err_o(x_wr_err),
    .axi_awid_o(x_awid), .axi_awaddr_o(x_awaddr),
    .axi_awlen_o(x_awlen), .axi_awsize_o(x_awsize),
    .axi_awburst_o(x_awburst), .axi_awlock_o(x_awlock),
    .axi_awcache_o(x_awcache), .axi_awprot_o(x_awprot),
    .axi_awqos_o(x_awqos), .axi_awregion_o(x_awregion),
    .axi_awvalid_o(x_awvalid), .axi_awready_i(awready),
    .axi_wdata_o(x_wdata), .axi_wstrb_o(x_wstrb),
    .axi_wlast_o(x_wlast), .axi_wvalid_o(x_wvalid),
    .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp),
    .axi_bvalid_i(bvalid), .axi_bready_o(x_bready),
    .axi_arid_o(x_arid), .axi_araddr_o(x_araddr),
    .axi_arlen_o(x_arlen), .axi_arsize_o(x_arsize),
    .axi_arburst_o(x_arburst), .axi_arlock_o(x_arlock),
    .axi_arcache_o(x_arcache), .axi_arprot_o(x_arprot),
    .axi_arqos_o(x_arqos), .axi_arregion_o(x_arregion),
    .axi_arvalid_o(x_arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata),
    .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(x_rready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // First requesting port at or after ptr
  function automatic int pick(input logic [NP-1:0] req,
                              input int ptr);
    for (int i = 0; i < NP; i++) begin
      if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return 0;
  endfunction

  task automatic wait_ar();
    int n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_wait", arvalid, 1'b1);
  endtask

  task automatic rd_txn(input int p, input int eb,
                        input bit keep);
    logic [31:0] a, d;
    logic [NP-1:0] oh;
    oh = NP'(1) << p;
    a = rd_addr[p*32 +: 32];
    wait_ar();
    chk("araddr", araddr, a & ~32'hF);
    chk("x_araddr", x_araddr, a & ~32'h3);
    chk("arlen", arlen, 8'd3);
    chk("arburst", arburst, 2'b01);
    chk("x_arburst", x_arburst, 2'b10);
    chk("arsize", arsize, 3'd2);
    chk("arcache", arcache, 4'b0011);
    repeat ($urandom_range(0, 2)) begin
      chk("rd_ready_early", rd_ready, '0);
      @(negedge clk);
      chk("arvalid_hold", arvalid, 1'b1);
    end
    arready = 1'b1;
    #1;
    chk("rd_ready", rd_ready, oh);
    chk("x_rd_ready", x_rd_ready, oh);
    @(negedge clk);
    arready = 1'b0;
    if (!keep) rd_valid[p] = 1'b0;
    chk("rready", rready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        rvalid = 1'b0;
        #1;
        chk("rvalid_gap", rd_rvalid, '0);
        @(negedge clk);
      end
      d = $urandom;
      rvalid = 1'b1;
      rdata = d;
      rlast = (b == 3);
      rresp = (b == eb) ? 2'b10 : 2'b00;
      #1;
      chk("rd_rvalid", rd_rvalid, oh);
      chk("rd_rdata", rd_rdata, d);
      chk("x_rd_rdata", x_rd_rdata, d);
      chk("rd_rlast", rd_rlast, b == 3);
      chk("rd_err", rd_err, (b == 3) && (eb >= 0));
      @(negedge clk);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    #1;
    chk("rready_done", rready, 1'b0);
    rd_ptr = (p + 1) % NP;
  endtask

  task automatic wr_req(input int p, input int awd,
                        input int wd);
    int n = 0;
    int m;
    m = (awd > wd) ? awd : wd;
    while (!awvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_wait", awvalid, 1'b1);
    chk("wvalid_with_aw", wvalid, 1'b1);
    chk("awaddr", awaddr, wr_addr[p*32 +: 32]);
    chk("awlen", awlen, 8'd0);
    chk("awburst", awburst, 2'b01);
    chk("wlast", wlast, 1'b1);
    chk("wdata", wdata, wr_wdata[p*32 +: 32]);
    chk("wstrb", wstrb, wr_wstrb[p*4 +: 4]);
    for (int c = 0; c <= m; c++) begin
      awready = (c == awd);
      wready = (c == wd);
      #1;
      chk("awvalid_c", awvalid, c <= awd);
      chk("wvalid_c", wvalid, c <= wd);
      chk("bready_req", bready, 1'b0);
      @(negedge clk);
    end
    awready = 1'b0;
    wready = 1'b0;
  endtask

  task automatic wr_resp(input int p, input logic [1:0] br);
    chk("bready", bready, 1'b1);
    chk("awvalid_resp", awvalid, 1'b0);
    repeat ($urandom_range(0, 2)) begin
      #1;
      chk("wr_ready_early", wr_ready, '0);
      @(negedge clk);
    end
    bvalid = 1'b1;
    bresp = br;
    #1;
    chk("wr_ready", wr_ready, NP'(1) << p);
    chk("wr_err", wr_err, br != 2'b00);
    @(negedge clk);
    bvalid = 1'b0;
    bresp = 2'b00;
    wr_valid[p] = 1'b0;
    #1;
    chk("bready_done", bready, 1'b0);
    chk("wr_ready_once", wr_ready, '0);
    wr_ptr = (p + 1) % NP;
  endtask

  task automatic set_wr(input int p, input logic [31:0] a);
    wr_addr[p*32 +: 32] = a;
    wr_wdata[p*32 +: 32] = $urandom;
    wr_wstrb[p*4 +: 4] = 4'($urandom_range(1, 15));
    wr_valid[p] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [NP-1:0] v;
    rd_valid = '0; rd_addr = '0;
    wr_valid = '0; wr_addr = '0;
    wr_wdata = '0; wr_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0;
    rdata = 0; bid = 0; rid = 0;

    repeat (3) @(negedge clk);
    chk("rst_valids",
        {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_pulses", {rd_ready, wr_ready, rd_rvalid}, 0);
    chk("rst_errs", {rd_err, wr_err, rd_rlast}, 0);
    chk("regions", {arregion, awregion, arid, awid}, 0);
    arst_n = 1'b1;
    @(negedge clk);

    rd_addr[31:0] = 32'h100;
    rd_valid = 2'b01;
    p = pick(rd_valid, rd_ptr);
    rd_txn(p, -1, 0);

    rd_addr[63:32] = 32'h10C;
    rd_valid = 2'b10;
    p = pick(rd_valid, rd_ptr);
    rd_txn(p, -1, 0);

    rd_addr = {$urandom, $urandom};
    rd_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      p = pick(rd_valid, rd_ptr);
      rd_txn(p, -1, 1);
    end
    rd_valid = '0;

    for (int k = 0; k < 6; k++) begin
      v = NP'($urandom_range(1, 3));
      rd_addr = {$urandom, $urandom};
      rd_valid = v;
      p = pick(v, rd_ptr);
      rd_txn(p, int'($urandom_range(0, 4)) - 1, 0);
      rd_valid = '0;
    end

    set_wr(0, 32'h200);
    p = pick(wr_valid, wr_ptr);
    wr_req(p, 0, 3);
    wr_resp(p, 2'b10);

    set_wr(1, $urandom);
    p = pick(wr_valid, wr_ptr);
    wr_req(p, 2, 0);
    wr_resp(p, 2'b00);

    for (int k = 0; k < 3; k++) begin
      v = NP'($urandom_range(1, 3));
      for (int q = 0; q < NP; q++)
        if (v[q]) set_wr(q, $urandom);
      p = pick(v, wr_ptr);
      wr_req(p, $urandom_range(0, 3), $urandom_range(0, 3));
      wr_resp(p, 2'($urandom_range(0, 3)));
      wr_valid = '0;
    end

    set_wr(0, 32'h200);
    p = pick(wr_valid, wr_ptr);
    wr_req(p, 1, 0);
    rd_addr[63:32] = 32'h204;
    rd_valid = 2'b10;
    repeat (4) begin
      @(negedge clk);
      chk("raw_block", arvalid, 1'b0);
    end
    rd_addr[31:0] = 32'h300;
    rd_valid = 2'b11;
    rd_txn(0, -1, 0);
    repeat (2) begin
      @(negedge clk);
      chk("raw_still", arvalid, 1'b0);
    end
    wr_resp(p, 2'b00);
    p = pick(rd_valid, rd_ptr);
    rd_txn(p, -1, 0);

    rd_addr[31:0] = $urandom;
    rd_valid = 2'b01;
    wait_ar();
    arready = 1'b1;
    #1;
    chk("rst_burst_ready", rd_ready, 2'b01);
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1;
      rdata = $urandom;
      #1;
      chk("rst_burst_beat", rd_rvalid, 2'b01);
      @(negedge clk);
    end
    arst_n = 1'b0;
    #1;
    chk("mid_rst_rready", rready, 1'b0);
    chk("mid_rst_rvalid", rd_rvalid, '0);
    chk("mid_rst_out", {arvalid, rd_ready, rd_rlast}, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold", {rready, rd_err}, 0);
    rvalid = 1'b0;
    arst_n = 1'b1;
    rd_ptr = 0;
    wr_ptr = 0;
    p = pick(rd_valid, rd_ptr);
    rd_txn(p, 2, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
